// File: rtl/pc_ras_unit_pkg.sv
// Shared defaults and select encoding for the fetch PC / return-address-stack unit.
package pc_ras_unit_pkg;
    localparam int ADDR_DEF      = 32;
    localparam int FETCH_W_DEF   = 1;
    localparam int RAS_DEPTH_DEF = 4;
    localparam int RESET_VEC_DEF = 0;
    localparam int TRAP_VEC_DEF  = 'h10;
    localparam int RAS_PTR_W_DEF = $clog2(RAS_DEPTH_DEF);

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_TRAP,
        SEL_RET,
        SEL_BRANCH
    } pc_sel_e;
endpackage

// File: rtl/pc_ras_unit_ras_stack.sv
// Circular return-address stack with saturating count; the oldest entry is overwritten when full.
module ras_stack
    import pc_ras_unit_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int W     = ADDR_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     push_data,
    output logic [W-1:0]     top_data,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] wr_idx;
    logic             do_pop;
    logic             replace;

    assign do_pop   = pop && (count != '0);
    assign replace  = push && do_pop;
    assign top_data = mem[top];

    always_comb begin
        wr_idx = top + PTR_W'(1);
        if (replace) wr_idx = top;
    end

    // Entry contents carry no reset; only pointer and count are architectural.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top   <= '0;
            count <= '0;
        end else if (replace) begin
            top   <= top;
            count <= count;
        end else if (push) begin
            top <= top + PTR_W'(1);
            if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
        end else if (do_pop) begin
            top   <= top - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/pc_ras_unit.sv
// Fetch program counter: stride increment, stall hold, branch/trap redirect, RAS call/return prediction.
module pc_ras_unit
    import pc_ras_unit_pkg::*;
#(
    parameter int ADDR      = ADDR_DEF,
    parameter int FETCH_W   = FETCH_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter logic [ADDR-1:0] RESET_VEC = ADDR'(RESET_VEC_DEF),
    parameter logic [ADDR-1:0] TRAP_VEC  = ADDR'(TRAP_VEC_DEF),
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    output logic             stall_o,
    output logic [ADDR-1:0]  pc_o,
    output logic             redirect_o,
    input  logic             branch_i,
    input  logic [ADDR-1:0]  branch_addr_i,
    input  logic             call_i,
    input  logic             ret_i,
    input  logic             trap_i,
    output logic [CNT_W-1:0] ras_count_o,
    output logic             ras_uflow_o
);
    logic [ADDR-1:0] pc_r;
    logic [ADDR-1:0] pc_next;
    logic [ADDR-1:0] pc_seq;
    logic [ADDR-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_nonempty;
    logic            uflow_d;
    pc_sel_e         sel;

    assign pc_o         = pc_r;
    assign stall_o      = stall_i;
    assign pc_seq       = pc_r + ADDR'(FETCH_W);
    assign ras_nonempty = (ras_count_o != '0);

    always_comb begin
        sel      = SEL_SEQ;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        uflow_d  = 1'b0;
        if (trap_i) begin
            sel = SEL_TRAP;
        end else if (ret_i && ras_nonempty) begin
            sel      = SEL_RET;
            ras_pop  = 1'b1;
            ras_push = call_i && branch_i;
        end else if (branch_i) begin
            sel      = SEL_BRANCH;
            ras_push = call_i;
            uflow_d  = ret_i;
        end else begin
            uflow_d = ret_i;
        end
    end

    always_comb begin
        pc_next = pc_r;
        case (sel)
            SEL_TRAP:   pc_next = TRAP_VEC;
            SEL_RET:    pc_next = ras_top;
            SEL_BRANCH: pc_next = branch_addr_i;
            default:    pc_next = stall_i ? pc_r : pc_seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= RESET_VEC;
            redirect_o  <= 1'b0;
            ras_uflow_o <= 1'b0;
        end else begin
            pc_r        <= pc_next;
            redirect_o  <= (sel != SEL_SEQ);
            ras_uflow_o <= uflow_d;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top_data  (ras_top),
        .count     (ras_count_o)
    );
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised next-generation fetch program counter. Generates the fetch address with a configurable fetch stride, stall hold, branch redirect and trap vectoring. Adds an internal circular return-address stack (RAS) for call/return prediction. Sits at the head of the fetch stage and drives the instruction-memory address and the fetch/decode pipeline register.

Parameters:
ADDR, 32, PC width in bits
FETCH_W, 1, instructions per fetch; sequential increment amount
RAS_DEPTH, 4, return-address stack entries; power of two, minimum 2
RESET_VEC, 0, PC value loaded on reset
TRAP_VEC, 'h10, PC value loaded on trap_i

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall_i  in  1  downstream stall; hold PC
stall_o  out  1  stall_i passed through combinationally
pc_o  out  ADDR  current fetch address (= pc_r)
redirect_o  out  1  registered; 1 for the cycle after any PC redirect (trap, branch or ret)
branch_i  in  1  redirect to branch_addr_i
branch_addr_i  in  ADDR  branch/call target
call_i  in  1  qualifies branch_i as a call; push pc_r+FETCH_W
ret_i  in  1  return; PC <= RAS top, pop
trap_i  in  1  redirect to TRAP_VEC
ras_count_o  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_uflow_o  out  1  registered 1-cycle pulse: ret_i with empty RAS

Behaviour:
- Reset: synchronous and active-high; one clock, clk; ports named clk and reset.
  - Values set on a clk edge with reset=1: pc_r=RESET_VEC, RAS top pointer=0, ras_count_o=0, redirect_o=0, ras_uflow_o=0.
  - RAS entry contents are don't-care.
  - Reset overrides every other input, including mid-stall and mid-redirect.
- pc_o = pc_r always. No combinational mux to a previous PC; a stalled PC is simply held.
- Next-PC priority (highest first), evaluated each clk edge with reset=0:
  1. trap_i: pc_r <= TRAP_VEC. RAS untouched. call_i/ret_i ignored.
  2. ret_i with ras_count_o>0: pc_r <= RAS top. The ret may also be paired with call_i & branch_i (see simultaneous call+ret below).
  3. branch_i: pc_r <= branch_addr_i. If call_i is also set, push.
  4. ret_i with ras_count_o==0: underflow. ras_uflow_o pulses next cycle. Fall through to rule 5 or 6.
  5. stall_i: hold pc_r.
  6. Otherwise: pc_r <= pc_r + FETCH_W, modulo 2^ADDR; wraps from all-ones.
- Redirects (rules 1-3) take effect even when stall_i=1.
- redirect_o <= 1 whenever rule 1, 2 or 3 fired; else 0.
- call_i without branch_i is ignored (no push).
- RAS push:
  - Write pc_r+FETCH_W at top+1; top <= top+1 (mod RAS_DEPTH).
  - count <= min(count+1, RAS_DEPTH).
  - When full, the oldest entry is silently overwritten (circular).
- RAS pop: read entry[top]; top <= top-1 (mod RAS_DEPTH); count <= count-1.
- Simultaneous call+ret (branch_i=call_i=ret_i=1, count>0):
  - pc_r <= old top.
  - entry[top] <= pc_r+FETCH_W.
  - Pointer and count unchanged.
- Simultaneous ret+branch without call, count>0: ret wins; the branch is dropped.
- Arithmetic: all adds are ADDR bits wide; carry discarded.
- stall_o = stall_i combinationally. No other combinational input-to-output paths.

Decomposition:
- Shared params include: ADDR default; RESET_VEC and TRAP_VEC constants; a localparam for the RAS pointer width, $clog2(RAS_DEPTH).
- One sub-module: ras_stack.
  - Ports: clk, reset, push, pop, push_data, top_data, count.
  - Contains the circular buffer, pointer and saturating count, including the push+pop replace case.
- pc_ras_unit holds the priority mux, pc_r, redirect_o and ras_uflow_o.

Test Plan:
- Reset/increment: FETCH_W=2; deassert reset → pc_o = 0, 2, 4, 6 on successive cycles. Assert reset mid-count at pc_o=6 → next pc_o=0, ras_count_o=0.
- Stall vs branch: stall_i=1 at pc_o=8 for 3 cycles → pc_o stays 8. In the 2nd stall cycle, branch_i=1 to 'h40 → next pc_o='h40, redirect_o=1 for exactly one cycle.
- Call/ret:
  - FETCH_W=1, at pc_o='h20: call to 'h100 → pc_o='h100, ras_count_o=1.
  - Later ret_i → pc_o='h21, ras_count_o=0, redirect_o=1.
- RAS overflow/underflow:
  - RAS_DEPTH=4; 5 nested calls from pc 1,2,3,4,5 → count saturates at 4.
  - 4 rets → targets 6,5,4,3.
  - 5th ret → ras_uflow_o=1, PC increments normally.
- Priority: trap_i, branch_i, call_i and ret_i all asserted with count=2 → pc_o=TRAP_VEC='h10, ras_count_o stays 2.
- Simultaneous call+ret: count=1, top='h50, pc_o='h30, call to 'h90 with ret_i → pc_o='h50, ras_count_o=1, next ret → pc_o='h31.
- Wrap: ADDR=8, pc_o='hFF, no stall → next pc_o='h00.
